// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads the combinational instruction memory and
// buffers {pc, instr} pairs in a small FIFO drained by decode via valid/ready.
// A redirect flushes the buffer and reloads the PC; a bad PC halts fetch.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        fetch_fault
);

    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

    logic [31:0]      r_pc;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;
    logic             r_fault;
    logic [31:0]      r_mem_pc    [DEPTH];
    logic [31:0]      r_mem_instr [DEPTH];

    logic             w_pop;
    logic             w_push;
    logic             w_pc_bad;
    logic [CNT_W-1:0] w_count_nxt;

    // Handshake, fault detection and push/pop qualification
    always_comb begin
        w_pop       = r_valid & out_ready;
        w_pc_bad    = (r_pc[1:0] != 2'b00) | (r_pc > LAST_PC);
        w_push      = !redirect_valid & !r_fault & !w_pc_bad &
                      ((r_count < CNT_W'(DEPTH)) | w_pop);
        w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    // PC, pointers, occupancy and sticky fault; redirect wins over everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_fault  <= 1'b0;
        end else if (redirect_valid) begin
            r_pc     <= redirect_target;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            if (w_push) begin
                r_pc     <= r_pc + 32'd4;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_pc_bad) begin
                r_fault <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
        end
    end

    // FIFO storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_pc;
            r_mem_instr[r_wr_ptr] <= imem_instr;
        end
    end

    // Outputs driven directly from registered state
    always_comb begin
        imem_addr    = r_pc;
        out_valid    = r_valid;
        out_instr    = r_mem_instr[r_rd_ptr];
        out_pc       = r_mem_pc[r_rd_ptr];
        out_pc_plus4 = r_mem_pc[r_rd_ptr] + 32'd4;
        fetch_fault  = r_fault;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural instruction memory
// and a queue of expected PCs consumed whenever decode accepts an entry.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;
    int n_pops = 0;
    logic [31:0] exp_q [$];

    instruction_fetch #(
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (2),
        .MEM_BYTES (1024)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_pc_plus4    (out_pc_plus4),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    // Program image: four known words, then an address-derived pattern
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h1300_0000;
            32'h4:   return 32'h0010_0093;
            32'h8:   return 32'h0020_0113;
            32'hC:   return 32'h0020_81b3;
            default: return (a * 32'h0100_0193) ^ 32'h5A5A_0000;
        endcase
    endfunction

    always_comb imem_instr = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // One clock: score any handshake at the negedge, then return #1 after posedge
    task automatic cyc();
        logic [31:0] e;
        @(negedge clk);
        if (rst_n && out_valid && out_ready && !redirect_valid) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                check("unexpected_pop_pc", out_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("head_pc", out_pc, e);
                check("head_instr", out_instr, mem_word(e));
                check("head_pc_plus4", out_pc_plus4, e + 32'd4);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        out_ready = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        exp_q.delete();
        redirect_valid = 1'b1;
        redirect_target = tgt;
        cyc();
        redirect_valid = 1'b0;
    endtask

    initial begin
        // Streaming from reset: exactly 0,4,8,12 in five cycles
        do_reset();
        expect_seq(32'h0, 8);
        out_ready = 1'b1;
        n_pops = 0;
        for (int i = 0; i < 5; i++) cyc();
        check("stream_pops", 32'(n_pops), 32'd4);

        // Backpressure: buffer fills with pc 0 and 4, PC parks at 8
        do_reset();
        expect_seq(32'h0, 64);
        for (int i = 0; i < 5; i++) cyc();
        check("bp_imem_addr", imem_addr, 32'h8);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_head_pc", out_pc, 32'h0);

        // Full buffer with ready: push and pop together, occupancy stays 2
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("full_valid", 32'(out_valid), 32'd1);
            check("full_depth", imem_addr - out_pc, 32'd8);
        end

        // Redirect with two buffered entries and ready high
        redirect(32'h10);
        expect_seq(32'h10, 16);
        check("redir_flush_valid", 32'(out_valid), 32'd0);
        check("redir_imem_addr", imem_addr, 32'h10);
        cyc();
        check("redir_valid", 32'(out_valid), 32'd1);
        check("redir_pc", out_pc, 32'h10);
        cyc();

        // Misaligned target faults one edge later and stays halted
        redirect(32'h6);
        check("mis_fault_early", 32'(fetch_fault), 32'd0);
        cyc();
        check("mis_fault", 32'(fetch_fault), 32'd1);
        check("mis_valid", 32'(out_valid), 32'd0);
        cyc();
        cyc();
        check("mis_fault_sticky", 32'(fetch_fault), 32'd1);
        check("mis_valid_held", 32'(out_valid), 32'd0);
        check("mis_pc_held", imem_addr, 32'h6);

        // Redirect clears the fault and restarts fetch
        redirect(32'h20);
        expect_seq(32'h20, 16);
        check("clr_fault", 32'(fetch_fault), 32'd0);
        cyc();
        check("clr_valid", 32'(out_valid), 32'd1);
        check("clr_pc", out_pc, 32'h20);
        cyc();

        // End of memory: 0x3FC delivered, then 0x400 faults
        redirect(32'h3F0);
        expect_seq(32'h3F0, 4);
        n_pops = 0;
        for (int i = 0; i < 7; i++) cyc();
        check("eom_pops", 32'(n_pops), 32'd4);
        check("eom_fault", 32'(fetch_fault), 32'd1);
        check("eom_valid", 32'(out_valid), 32'd0);
        check("eom_imem_addr", imem_addr, 32'h400);
        check("eom_queue_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a stream
        redirect(32'h100);
        expect_seq(32'h100, 16);
        cyc();
        cyc();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_imem_addr", imem_addr, 32'h0);
        check("async_rst_fault", 32'(fetch_fault), 32'd0);
        cyc();
        rst_n = 1'b1;
        exp_q.delete();
        expect_seq(32'h0, 4);
        out_ready = 1'b1;
        cyc();
        check("post_rst_pc", out_pc, 32'h0);
        check("post_rst_instr", out_instr, 32'h1300_0000);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
